mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port main memory (32-bit data, 16-bit word address) between two requesters. Typical pairing: port 0 for the CPU fetch/data path, port 1 for a program loader or DMA engine. Each requester uses a req/ack handshake. The block sequences one memory transaction at a time onto `MAR`/`MBR_W`/`write`, waits the fixed memory latency, then returns the read data with a one-cycle `ack`.

## Interface
Parameters:
- `BITS_DATA`, default 32: data word width.
- `BITS_ADDR`, default 16: word address width.
- `MEM_LAT`, default 1: cycles from `MAR` valid to `MBR_R` valid. Legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high reset.
- `req0`, `req1` input 1: transaction request from port 0 / port 1.
- `we0`, `we1` input 1: 1 = write, 0 = read.
- `addr0`, `addr1` input `BITS_ADDR`: word address.
- `wdata0`, `wdata1` input `BITS_DATA`: write data.
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `rdata` output `BITS_DATA`: read data, shared by both ports and valid while `ackN` is high.
- `gnt_id` output 1: port owning the current or most recent transaction.
- `busy` output 1: high in any state other than IDLE.
- `MAR` output `BITS_ADDR`: memory address.
- `MBR_W` output `BITS_DATA`: memory write data.
- `write` output 1: memory write enable.
- `MBR_R` input `BITS_DATA`: memory read data.

## Operation
- States: IDLE, WAIT, DONE. Counter `cnt` is 4 bits.
- **IDLE.**
  - No request: stay in IDLE.
  - Any request: select a winner, latch `MAR` and `MBR_W` from the winner's `addr`/`wdata`, set `write` from the winner's `we`, set `gnt_id`, load `cnt` = `MEM_LAT`, go to WAIT.
- **WAIT.**
  - Decrement `cnt` each edge.
  - On the edge where `cnt` == 1: capture `rdata` <= `MBR_R` (captured for writes too), set `write` <= 0, assert `ack[gnt_id]` <= 1, go to DONE.
- **DONE.**
  - Deassert `ack`, go to IDLE.
  - `req` inputs are ignored in DONE.
- **Arbitration (round-robin).**
  - One request: it wins.
  - Both requesting: the port not granted last wins.
  - `gnt_id` resets to 1, so port 0 wins the first tie.
- **Requester rules.**
  - Hold `req`, `we`, `addr`, `wdata` stable until `ack` is seen.
  - Drop `req` on the edge ending the ack cycle unless another transaction is wanted.
  - A held `req` is re-arbitrated in IDLE, so alternation is guaranteed under contention.
- `MAR` and `MBR_W` hold their last values after completion. Only `write` returns to 0.
- At most one `ackN` is high in any cycle.

## Timing
- **Reset values:** state IDLE, `MAR` 0, `MBR_W` 0, `write` 0, `ack0`/`ack1` 0, `rdata` 0, `gnt_id` 1, `busy` 0, `cnt` 0.
- **Reset mid-transaction:** outputs return to reset values immediately (asynchronously), including `write` dropping to 0. The transaction is discarded with no ack; the requester must re-issue it.
- **Latency:** request sampled at edge E0 (IDLE). Memory signals are valid after E0. `ack` is high in the cycle after edge E0+`MEM_LAT`.
- **Throughput:** one transaction per `MEM_LAT`+2 cycles.
- **Write pulse:** `write` is high for exactly `MEM_LAT` cycles.
- **Simultaneous events:** a request rising in a WAIT or DONE cycle waits for IDLE; it is not lost as long as it is held.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Port 0 always wins when both request, and port 1 can starve.
  - Undefined (default): round-robin as specified above.
- Both modes share all other timing.

## Test plan
- **Reset:** assert `reset` mid-WAIT of a write to address 0x0010 -> `write` = 0 the same cycle, no ack, `busy` = 0; after release, the first request is served normally.
- **Single read:** `MEM_LAT` = 1, memory preloaded 0x0042 = 0xDEADBEEF; `req0` read 0x0042 -> `MAR` = 0x0042 after E0, `ack0` high in cycle E0+2, `rdata` = 0xDEADBEEF, `ack1` never set.
- **Write then read-back:** port 1 writes 0xCAFEF00D to 0x1234 with `MEM_LAT` = 3 -> `write` high exactly 3 cycles; a following read of 0x1234 returns 0xCAFEF00D.
- **Contention:** `req0` and `req1` held high for 4 transactions -> grant order 0,1,0,1; 4 acks, each `MEM_LAT`+2 cycles apart. With `MEM_ARB_FIXED_PRIO_EN`: order 0,0,0,0 and `ack1` never set.
- **Late request:** `req1` rises during port 0's WAIT -> port 1 is served in the next IDLE and `ack1` follows `ack0` by `MEM_LAT`+2 cycles.
- **Address wrap:** read at 0xFFFF followed by read at 0x0000 -> both complete and `MAR` shows the exact addresses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port req/ack arbiter in front of a single-port memory with fixed read latency.
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; round-robin otherwise.
module mem_port_arbiter #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata0,
    input  logic [BITS_DATA-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [BITS_DATA-1:0] rdata,
    output logic                 gnt_id,
    output logic                 busy,
    output logic [BITS_ADDR-1:0] MAR,
    output logic [BITS_DATA-1:0] MBR_W,
    output logic                 write,
    input  logic [BITS_DATA-1:0] MBR_R
);
    localparam int         NUM_PORTS = 2;
    localparam logic [3:0] LAT       = 4'(MEM_LAT);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic                 we;
        logic [BITS_ADDR-1:0] addr;
        logic [BITS_DATA-1:0] wdata;
    } port_req_t;

    port_req_t [NUM_PORTS-1:0] preq;
    logic      [NUM_PORTS-1:0] req_vec;
    logic      [NUM_PORTS-1:0] ack;
    port_req_t                 sel;
    logic                      win;
    state_t                    state;
    logic      [3:0]           cnt;

    assign req_vec = {req1, req0};
    assign preq[0] = '{we: we0, addr: addr0, wdata: wdata0};
    assign preq[1] = '{we: we1, addr: addr1, wdata: wdata1};
    assign ack0    = ack[0];
    assign ack1    = ack[1];

    // Winner is only consumed in IDLE when at least one request is present.
    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        win = ~req_vec[0];
`else
        win = (&req_vec) ? ~gnt_id : req_vec[1];
`endif
    end

    assign sel = preq[win];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            MAR    <= '0;
            MBR_W  <= '0;
            write  <= 1'b0;
            ack    <= '0;
            rdata  <= '0;
            gnt_id <= 1'b1;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        state  <= WAIT;
                        busy   <= 1'b1;
                        gnt_id <= win;
                        MAR    <= sel.addr;
                        MBR_W  <= sel.wdata;
                        write  <= sel.we;
                        cnt    <= LAT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Last latency edge: MBR_R is valid now, for writes too.
                    if (cnt == 4'd1) begin
                        rdata       <= MBR_R;
                        write       <= 1'b0;
                        ack[gnt_id] <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= '0;
                    write <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) share clk/reset,
// each with its own behavioural memory (preset contents plus write overlay).
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [15:0] addr0 [2], addr1 [2];
    logic [31:0] wdata0 [2], wdata1 [2];

    logic        a_ack0, a_ack1, a_gnt, a_busy, a_write, b_ack0, b_ack1, b_gnt, b_busy, b_write;
    logic [31:0] a_rdata, a_mbr_w, a_mbr_r, b_rdata, b_mbr_w, b_mbr_r;
    logic [15:0] a_mar, b_mar;

    logic        ack0 [2], ack1 [2], gnt_id [2], busy [2], write [2];
    logic [31:0] rdata [2], mbr_w [2];
    logic [15:0] mar [2];

    always_comb begin
        ack0[0] = a_ack0;   ack0[1] = b_ack0;
        ack1[0] = a_ack1;   ack1[1] = b_ack1;
        gnt_id[0] = a_gnt;  gnt_id[1] = b_gnt;
        busy[0] = a_busy;   busy[1] = b_busy;
        write[0] = a_write; write[1] = b_write;
        rdata[0] = a_rdata; rdata[1] = b_rdata;
        mbr_w[0] = a_mbr_w; mbr_w[1] = b_mbr_w;
        mar[0] = a_mar;     mar[1] = b_mar;
    end

    mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata), .gnt_id(a_gnt), .busy(a_busy),
        .MAR(a_mar), .MBR_W(a_mbr_w), .write(a_write), .MBR_R(a_mbr_r)
    );

    mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .gnt_id(b_gnt), .busy(b_busy),
        .MAR(b_mar), .MBR_W(b_mbr_w), .write(b_write), .MBR_R(b_mbr_r)
    );

    // Memory: preset contents from init_val, overridden by anything written.
    bit [31:0] mem  [2][0:65535];
    bit        wvld [2][0:65535];

    function automatic logic [31:0] init_val(input logic [15:0] a);
        case (a)
            16'h0042: init_val = 32'hDEADBEEF;
            16'hFFFF: init_val = 32'h1111FFFF;
            16'h0000: init_val = 32'h22220000;
            default:  init_val = {~a, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (a_write) begin mem[0][a_mar] <= a_mbr_w; wvld[0][a_mar] <= 1'b1; end
        if (b_write) begin mem[1][b_mar] <= b_mbr_w; wvld[1][b_mar] <= 1'b1; end
    end

    assign a_mbr_r = wvld[0][a_mar] ? mem[0][a_mar] : init_val(a_mar);
    assign b_mbr_r = wvld[1][b_mar] ? mem[1][b_mar] : init_val(b_mar);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int d, input bit p, input bit r, input bit w,
                         input logic [15:0] a, input logic [31:0] wd);
        if (p) begin req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = wd; end
        else   begin req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = wd; end
    endtask

    // One isolated transaction, entered and left at a negedge in IDLE.
    task automatic xact(input int d, input bit p, input bit w, input logic [15:0] a,
                        input logic [31:0] wd, input bit chk_rd, input logic [31:0] exp_rd);
        int j = 0;
        int wcnt = 0;
        drive(d, p, 1'b1, w, a, wd);
        tick;
        chk("x_mar", mar[d], a);
        chk("x_busy", busy[d], 1);
        chk("x_gnt", gnt_id[d], p);
        if (w) chk("x_mbrw", mbr_w[d], wd);
        while (!(p ? ack1[d] : ack0[d]) && j < 20) begin
            if (write[d]) wcnt++;
            tick;
            j++;
        end
        chk("x_lat", j, lat(d));
        chk("x_wpulse", wcnt, w ? lat(d) : 0);
        chk("x_other_ack", p ? ack0[d] : ack1[d], 0);
        chk("x_write_off", write[d], 0);
        if (chk_rd) chk("x_rdata", rdata[d], exp_rd);
        drive(d, p, 1'b0, 1'b0, a, wd);
        tick;
        chk("x_ack_clr", p ? ack1[d] : ack0[d], 0);
        chk("x_idle", busy[d], 0);
        chk("x_mar_hold", mar[d], a);
    endtask

    initial begin
        bit [3:0] exp_order;
        int       t0;
        int       last;
        int       j;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 0; req1[d] = 0; we0[d] = 0; we1[d] = 0;
            addr0[d] = '0; addr1[d] = '0; wdata0[d] = '0; wdata1[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_mar", mar[d], 0);
            chk("rst_mbrw", mbr_w[d], 0);
            chk("rst_write", write[d], 0);
            chk("rst_ack0", ack0[d], 0);
            chk("rst_ack1", ack1[d], 0);
            chk("rst_rdata", rdata[d], 0);
            chk("rst_gnt", gnt_id[d], 1);
            chk("rst_busy", busy[d], 0);
        end
        reset = 1'b0;
        tick;

        // Single read, latency 1.
        xact(0, 1'b0, 1'b0, 16'h0042, 32'h0, 1'b1, 32'hDEADBEEF);
        // Address wrap.
        xact(0, 1'b0, 1'b0, 16'hFFFF, 32'h0, 1'b1, 32'h1111FFFF);
        xact(0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 32'h22220000);
        // Write then read-back, latency 3.
        xact(1, 1'b1, 1'b1, 16'h1234, 32'hCAFEF00D, 1'b0, 32'h0);
        xact(1, 1'b0, 1'b0, 16'h1234, 32'h0, 1'b1, 32'hCAFEF00D);

        // Contention on the latency-1 instance; last grant was port 1 so port 0 wins first.
        xact(0, 1'b1, 1'b0, 16'h0042, 32'h0, 1'b1, 32'hDEADBEEF);
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;
`endif
        drive(0, 1'b0, 1'b1, 1'b0, 16'h0100, 32'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0200, 32'h0);
        last = 0;
        for (int k = 0; k < 4; k++) begin
            j = 0;
            while (!(ack0[0] || ack1[0]) && j < 30) begin tick; j++; end
            chk("cont_timeout", (j < 30) ? 1 : 0, 1);
            chk("cont_port", ack1[0], exp_order[k]);
            chk("cont_gnt", gnt_id[0], exp_order[k]);
            chk("cont_one_hot", ack0[0] & ack1[0], 0);
            chk("cont_rdata", rdata[0], exp_order[k] ? init_val(16'h0200) : init_val(16'h0100));
            if (k > 0) chk("cont_gap", cyc - last, 3);
            last = cyc;
            if (k == 3) begin
                drive(0, 1'b0, 1'b0, 1'b0, 16'h0100, 32'h0);
                drive(0, 1'b1, 1'b0, 1'b0, 16'h0200, 32'h0);
            end
            tick;
        end
        tick;
        chk("cont_idle", busy[0], 0);

        // Late request: port 1 rises during port 0's WAIT on the latency-3 instance.
        drive(1, 1'b0, 1'b1, 1'b0, 16'h0300, 32'h0);
        tick;
        chk("late_gnt0", gnt_id[1], 0);
        tick;
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0400, 32'h0);
        j = 0;
        while (!ack0[1] && j < 20) begin tick; j++; end
        chk("late_ack0_seen", ack0[1], 1);
        chk("late_rdata0", rdata[1], init_val(16'h0300));
        t0 = cyc;
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0300, 32'h0);
        tick;
        j = 0;
        while (!ack1[1] && j < 20) begin tick; j++; end
        chk("late_ack1_seen", ack1[1], 1);
        chk("late_gap", cyc - t0, 5);
        chk("late_gnt1", gnt_id[1], 1);
        chk("late_rdata1", rdata[1], init_val(16'h0400));
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0400, 32'h0);
        tick;

        // Reset in the middle of a write.
        drive(1, 1'b0, 1'b1, 1'b1, 16'h0010, 32'h0BADF00D);
        tick;
        tick;
        chk("rmid_write_hi", write[1], 1);
        chk("rmid_mar", mar[1], 16'h0010);
        reset = 1'b1;
        #1;
        chk("rmid_write_lo", write[1], 0);
        chk("rmid_busy", busy[1], 0);
        chk("rmid_mar_clr", mar[1], 0);
        chk("rmid_gnt", gnt_id[1], 1);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
        repeat (3) @(negedge clk);
        chk("rmid_no_ack", ack0[1], 0);
        reset = 1'b0;
        tick;
        xact(1, 1'b0, 1'b0, 16'h0042, 32'h0, 1'b1, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
